// File: rtl/display_pkg.sv
// Shared constants and state type for the display colour decoder.
package display_pkg;

  localparam int CYCLEWIDTH = 8;
  localparam int NUM_CH     = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } dec_state_e;

endpackage

// File: rtl/display_color_channel_counter.sv
// One colour channel: counts "on" sweep samples and converts the tally back
// into a channel value (count-1, with counts of 0 or 1 mapping to 0).
module display_color_channel_counter #(
  parameter int cyclewidth = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_acc,
  input  logic                  i_bit,
  output logic [cyclewidth-1:0] o_value
);

  logic [cyclewidth:0] r_count;
  logic [cyclewidth:0] w_sum;
  logic [cyclewidth:0] w_dec;

  // A sweep-start sample replaces the old tally instead of adding to it.
  assign w_sum = (i_load ? '0 : r_count) + {{cyclewidth{1'b0}}, i_bit};
  assign w_dec = w_sum - {{cyclewidth{1'b0}}, 1'b1};
  assign o_value = (w_sum <= {{cyclewidth{1'b0}}, 1'b1}) ? '0 : w_dec[cyclewidth-1:0];

  always_ff @(posedge clk) begin
    if (rst)                 r_count <= '0;
    else if (i_load | i_acc) r_count <= w_sum;
  end

endmodule

// File: rtl/display_color_decoder.sv
// Recovers a pixel from a PWM-style sweep of per-channel on/off bits.
// Optional sweep-order checking: define DISPLAY_COLOR_DECODER_SEQCHECK_EN.
module display_color_decoder
  import display_pkg::*;
#(
  parameter int cyclewidth = CYCLEWIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [cyclewidth-1:0]   cycle,
  input  logic [2:0]              rgb,
  output logic [3*cyclewidth-1:0] pixel,
  output logic                    out_valid,
  output logic                    seq_error
);

  localparam logic [cyclewidth-1:0] LAST = '1;

  dec_state_e                          r_state;
  logic [NUM_CH-1:0][cyclewidth-1:0]   r_pixel;
  logic                                r_out_valid;
  logic [NUM_CH-1:0][cyclewidth-1:0]   w_chan;
  logic                                w_start;
  logic                                w_in_accum;
  logic                                w_bad;
  logic                                w_acc;
  logic                                w_last;

  assign w_start    = in_valid & (cycle == '0);
  assign w_in_accum = in_valid & (r_state == ACCUM) & (cycle != '0);
  assign w_acc      = w_in_accum & ~w_bad;
  assign w_last     = w_acc & (cycle == LAST);

`ifdef DISPLAY_COLOR_DECODER_SEQCHECK_EN
  logic [cyclewidth-1:0] r_expected;
  logic                  r_seq_error;
  logic                  w_err;

  assign w_bad     = w_in_accum & (cycle != r_expected);
  // Restarting an unfinished sweep is also reported as a sequence fault.
  assign w_err     = w_bad | (w_start & (r_state == ACCUM));
  assign seq_error = r_seq_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_expected  <= '0;
      r_seq_error <= 1'b0;
    end else begin
      r_seq_error <= w_err;
      if (w_start)    r_expected <= {{(cyclewidth-1){1'b0}}, 1'b1};
      else if (w_acc) r_expected <= r_expected + 1'b1;
    end
  end
`else
  assign w_bad     = 1'b0;
  assign seq_error = 1'b0;
`endif

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      display_color_channel_counter #(.cyclewidth(cyclewidth)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_start),
        .i_acc   (w_acc),
        .i_bit   (rgb[g]),
        .o_value (w_chan[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pixel     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_last;
      if (w_start)     r_state <= ACCUM;
      else if (w_last) begin
        r_state <= IDLE;
        r_pixel <= w_chan;
      end else if (w_bad) r_state <= IDLE;
    end
  end

  assign pixel     = r_pixel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_display_color_decoder.sv
// Randomised and directed checks of display_color_decoder against a sweep-level model.
module tb_display_color_decoder;

`ifdef DISPLAY_COLOR_DECODER_SEQCHECK_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  cycle = '0;
  logic [2:0]  rgb = '0;
  logic [23:0] pixel;
  logic        out_valid, seq_error;

  logic        c2_valid = 1'b0;
  logic [1:0]  c2_cycle = '0;
  logic [2:0]  c2_rgb = '0;
  logic [5:0]  c2_pixel;
  logic        c2_ov, c2_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  display_color_decoder #(.cyclewidth(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cycle(cycle), .rgb(rgb),
    .pixel(pixel), .out_valid(out_valid), .seq_error(seq_error));

  display_color_decoder #(.cyclewidth(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(c2_valid), .cycle(c2_cycle), .rgb(c2_rgb),
    .pixel(c2_pixel), .out_valid(c2_ov), .seq_error(c2_err));

  // Sweep-level reference: integer tallies of "on" samples per channel.
  int          m_tally[3];
  bit          m_act;
  int          m_exp;
  logic [23:0] m_pix;
  bit          m_ov, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] enc(input logic [23:0] p, input int c);
    logic [2:0] b;
    for (int ch = 0; ch < 3; ch++) begin
      int v;
      v = int'(p[ch*8 +: 8]);
      b[ch] = (v >= c) && (v != 0);
    end
    return b;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 3; ch++) m_tally[ch] = 0;
    m_act = 0; m_exp = 0; m_pix = '0; m_ov = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input int c, input logic [2:0] b);
    m_ov = 0; m_err = 0;
    if (!v) return;
    if (c == 0) begin
      if (m_act && SEQ) m_err = 1;
      for (int ch = 0; ch < 3; ch++) m_tally[ch] = int'(b[ch]);
      m_act = 1; m_exp = 1;
    end else if (m_act) begin
      if (SEQ && c != m_exp) begin
        m_err = 1; m_act = 0;
      end else begin
        for (int ch = 0; ch < 3; ch++) m_tally[ch] += int'(b[ch]);
        m_exp = c + 1;
        if (c == 255) begin
          m_act = 0; m_ov = 1;
          for (int ch = 0; ch < 3; ch++)
            m_pix[ch*8 +: 8] = (m_tally[ch] <= 1) ? 8'd0 : 8'(m_tally[ch] - 1);
        end
      end
    end
  endtask

  task automatic step(input bit v, input int c, input logic [2:0] b);
    in_valid = v; cycle = 8'(c); rgb = b;
    @(posedge clk);
    model_step(v, c, b);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("seq_error", {31'd0, seq_error}, {31'd0, m_err});
    chk("pixel", {8'd0, pixel}, {8'd0, m_pix});
  endtask

  task automatic rst_step(input bit v, input int c, input logic [2:0] b);
    rst = 1'b1; in_valid = v; cycle = 8'(c); rgb = b;
    @(posedge clk);
    model_reset();
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_seq_error", {31'd0, seq_error}, 32'd0);
    chk("rst_pixel", {8'd0, pixel}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  int sw_ov, sw_err;

  // Drives cycles 0..255 of a sweep, optionally pausing, skipping one index,
  // or stopping early; counts observed out_valid/seq_error pulses.
  task automatic sweep(input logic [23:0] p, input int gap_at, input int gap_len,
                       input int skip, input int stop_at, input int gap_pct);
    for (int c = 0; c < 256; c++) begin
      if (c == stop_at) return;
      if (c == gap_at)
        for (int k = 0; k < gap_len; k++) step(0, c, 3'($urandom));
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) step(0, c, 3'($urandom));
      if (c == skip) continue;
      step(1, c, enc(p, c));
      sw_ov  += int'(out_valid);
      sw_err += int'(seq_error);
    end
  endtask

  initial begin
    logic [23:0] rp;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pixel", {8'd0, pixel}, 32'd0);
    chk("reset_ov", {31'd0, out_valid}, 32'd0);
    chk("reset_err", {31'd0, seq_error}, 32'd0);
    chk("reset_c2_pixel", {26'd0, c2_pixel}, 32'd0);
    rst = 1'b0;

    // Basic sweep, then a sweep with a 3-clock stall at cycle 100.
    sw_ov = 0; sw_err = 0;
    sweep(24'h0001FF, -1, 0, -1, -1, 0);
    chk("sweep1_ov_count", sw_ov, 1);
    chk("sweep1_pixel", {8'd0, pixel}, 32'h0001FF);
    sw_ov = 0;
    sweep(24'h807F00, 100, 3, -1, -1, 0);
    chk("stall_ov_count", sw_ov, 1);
    chk("stall_pixel", {8'd0, pixel}, 32'h807F00);

    // Restart after cycle 50.
    sw_ov = 0; sw_err = 0;
    sweep(24'h102030, -1, 0, -1, 51, 0);
    sweep(24'h102030, -1, 0, -1, -1, 0);
    chk("restart_ov_count", sw_ov, 1);
    chk("restart_err_count", sw_err, SEQ ? 1 : 0);
    chk("restart_pixel", {8'd0, pixel}, 32'h102030);

    // Skipped index 10, then stray non-zero samples.
    sw_ov = 0; sw_err = 0;
    sweep(24'h405060, -1, 0, 10, -1, 0);
    for (int c = 5; c < 12; c++) step(1, c, 3'b111);
    chk("skip_ov_count", sw_ov, SEQ ? 0 : 1);
    chk("skip_err_count", sw_err, SEQ ? 1 : 0);

    // Reset at cycle 200, then a full-scale sweep.
    sweep(24'h123456, -1, 0, -1, 200, 0);
    rst_step(1, 200, enc(24'h123456, 200));
    sw_ov = 0;
    sweep(24'hFFFFFF, -1, 0, -1, -1, 0);
    chk("full_ov_count", sw_ov, 1);
    chk("full_pixel", {8'd0, pixel}, 32'hFFFFFF);

    // Reset coinciding with the final sample wins.
    sweep(24'hA5A5A5, -1, 0, -1, 255, 0);
    rst_step(1, 255, enc(24'hA5A5A5, 255));
    step(0, 0, 3'b000);

    // Random sweeps with stalls, occasional aborts and stray samples.
    for (int it = 0; it < 20; it++) begin
      rp = 24'($urandom);
      if ($urandom_range(3) == 0) sweep(rp, -1, 0, -1, int'($urandom_range(1, 255)), 10);
      for (int k = 0; k < int'($urandom_range(3)); k++)
        step(1, int'($urandom_range(1, 255)), 3'($urandom));
      sw_ov = 0;
      sweep(rp, -1, 0, -1, -1, 15);
      chk("rand_ov_count", sw_ov, 1);
      chk("rand_pixel", {8'd0, pixel}, {8'd0, rp});
    end

    // cyclewidth=2: R=3, G=1, B=0.
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      c2_valid = 1'b1; c2_cycle = 2'(c);
      c2_rgb = {1'b1, (c <= 1), 1'b0};
      @(posedge clk); #1;
      chk("c2_ov", {31'd0, c2_ov}, (c == 3) ? 32'd1 : 32'd0);
      chk("c2_err", {31'd0, c2_err}, 32'd0);
    end
    c2_valid = 1'b0;
    chk("c2_pixel", {26'd0, c2_pixel}, {26'd0, 2'd3, 2'd1, 2'd0});
    @(posedge clk); #1;
    chk("c2_ov_single", {31'd0, c2_ov}, 32'd0);
    chk("c2_pixel_hold", {26'd0, c2_pixel}, {26'd0, 2'd3, 2'd1, 2'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
